pipe_free_multicycle_control: RTL and testbench
===============================================

PIPE_FREE_MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
- REQ-001 The block SHALL have these parameters:
  - CONTROL_SIZE, default 18: width of the control vector; must be >= 18; bits above 17 are driven 0.
  - OP_SIZE, default 6: opcode width.
  - FUNC_SIZE, default 6: function-field width.
  - COUNT_W, default 32: width of the retired-instruction counter.
- REQ-002 The block SHALL have these ports, clock and reset first:
  - i_clk  in  1  the single clock.
  - i_rst_n  in  1  reset; asynchronous assert, active-low.
  - i_enable  in  1  allows fetch of new instructions.
  - i_instr  in  32  instruction word; opcode = [31:26], func = [5:0].
  - i_instr_valid  in  1  instruction word is valid.
  - o_instr_ready  out  1  block can accept an instruction.
  - i_mem_ready  in  1  data-memory access complete.
  - o_control  out  CONTROL_SIZE  state-gated control vector.
  - o_state  out  3  current FSM state code.
  - o_ir_write  out  1  instruction-register capture strobe.
  - o_pc_write  out  1  retire / PC-update strobe.
  - o_illegal  out  1  one-cycle unknown-instruction pulse.
  - o_busy  out  1  an instruction is in flight.
  - o_instr_count  out  COUNT_W  retired-instruction count.

Function
- REQ-003 The FSM SHALL have these states and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- REQ-004 In FETCH, o_instr_ready SHALL equal i_enable; the handshake is i_instr_valid & o_instr_ready; on handshake, o_ir_write SHALL pulse and the next state SHALL be DECODE; otherwise the FSM SHALL stay in FETCH.
- REQ-005 DECODE SHALL latch the 18-bit vector from the team decode table in one cycle; the next state SHALL be EXEC, except for an unknown instruction: o_illegal and o_pc_write SHALL pulse, the counter SHALL NOT increment, and the next state SHALL be FETCH.
- REQ-006 Transitions after EXEC SHALL be:
  - ALU R/I types, including JAL and JALR: EXEC -> WB -> FETCH.
  - Loads: EXEC -> MEM -> WB -> FETCH.
  - Stores: EXEC -> MEM -> FETCH.
  - BEQ, BNE, J, JR: retire in EXEC, then FETCH.
- REQ-007 MEM SHALL hold until i_mem_ready=1, with no timeout; i_mem_ready outside MEM SHALL be ignored.
- REQ-008 o_control SHALL be 0 in FETCH, DECODE and HALT. In EXEC/MEM/WB it SHALL be the latched vector with these gates:
  - bit0 (REG_WRITE) only in WB;
  - bit3 (MEM_READ) and bit4 (MEM_WRITE) only in MEM;
  - all other bits unmodified.
- REQ-009 o_pc_write SHALL pulse for exactly one cycle on the retire cycle of every instruction:
  - the WB cycle;
  - the store's MEM cycle with i_mem_ready=1;
  - the branch/jump EXEC cycle;
  - the illegal DECODE cycle.
- REQ-010 o_instr_count SHALL increment by 1 on every legal retire and wrap from 2^COUNT_W-1 to 0.
- REQ-011 o_busy SHALL be 1 in every state except FETCH and HALT.
- REQ-012 Deasserting i_enable mid-instruction SHALL NOT abort it; the instruction completes and the FSM parks in FETCH with o_instr_ready=0.
- REQ-013 Minimum latencies from the handshake cycle to retire SHALL be: ALU 3 cycles, load 4, store 3, branch 2.

Reset
- REQ-014 Asserting i_rst_n=0 SHALL immediately force, regardless of state, including mid-MEM:
  - state FETCH;
  - latched vector, o_instr_count, o_control and all strobes to 0.
- REQ-015 The first handshake SHALL be possible on the first rising edge after i_rst_n deasserts.

Configuration
- REQ-016 With macro MC_HALT_DETECT_EN defined, opcode 6'b111111 SHALL retire (pulse o_pc_write, count +1) in DECODE and enter HALT, leaving HALT only by reset.
- REQ-017 Without MC_HALT_DETECT_EN, opcode 6'b111111 SHALL be treated as illegal, and the HALT state SHALL be unreachable.

Structure
- REQ-018 A shared package SHALL hold:
  - the control-bit index constants (REG_WRITE=0 ... JUMP_OR_B=17);
  - the opcode and func constants;
  - the state encoding;
  - the instruction-class enum (ALU, LOAD, STORE, BRANCH, ILLEGAL, HALT).
- REQ-019 A combinational sub-module, instr_class_decode, SHALL map {opcode, func} to the 18-bit vector plus the class; the FSM and registers live in multicycle_control.

Verification
- REQ-020 ADDU 0x00221821 handshake at cycle 0 -> o_control = 0x01C84 at cycle 2, 0x01C85 with o_pc_write at cycle 3; count=1.
- REQ-021 LW 0x8C220004, i_mem_ready held 0 for 3 MEM cycles -> o_control = 0x02608 throughout MEM, then 0x02601 in WB; retire at cycle 7.
- REQ-022 SW 0xAC220004 with i_mem_ready=1 at first MEM -> o_control = 0x00610 and o_pc_write in the same cycle; no WB state.
- REQ-023 Opcode 0xF8000000 (and 0xFC000000 without the macro) -> o_illegal pulse in DECODE, count unchanged, back in FETCH next cycle.
- REQ-024 Reset asserted during MEM of LW -> o_state=0, o_control=0 asynchronously; count preset via 2^COUNT_W-1 retires, with COUNT_W=4 (15 retires) -> 16th retire gives count=0.
- REQ-025 MC_HALT_DETECT_EN defined, 0xFC000000 -> o_state=5, o_instr_ready=0 and o_busy=0 until reset.

Source files
------------

// File: rtl/pipe_free_multicycle_control_pkg.sv
// Shared definitions for the multicycle control block: control-bit indices,
// opcode/func constants, FSM state encoding and instruction classes.
// Optional feature macro: MC_HALT_DETECT_EN (opcode 6'b111111 becomes HALT).
package pipe_free_multicycle_control_pkg;

    // Width of the decoded control vector (the decode table is 18 bits wide)
    localparam int CTRL_W = 18;

    // Control-bit positions inside the decoded vector
    localparam int REG_WRITE    = 0;
    localparam int SHIFT_SRC    = 1;
    localparam int REG_DST      = 2;
    localparam int MEM_READ     = 3;
    localparam int MEM_WRITE    = 4;
    localparam int BRANCH_EQ    = 5;
    localparam int BRANCH_NE    = 6;
    localparam int ALU_UNSIGNED = 7;
    localparam int ZERO_EXT     = 8;
    localparam int ALU_SRC_IMM  = 9;
    localparam int ALU_OP0      = 10;
    localparam int ALU_OP1      = 11;
    localparam int ALU_OP2      = 12;
    localparam int MEM_TO_REG   = 13;
    localparam int LINK         = 14;
    localparam int JUMP_REG     = 15;
    localparam int JUMP_IMM     = 16;
    localparam int JUMP_OR_B    = 17;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // Function fields for R-type (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef logic [CTRL_W-1:0] ctrl_vec_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_ILLEGAL = 3'd4,
        CLS_HALT    = 3'd5
    } instr_class_e;

    // One-hot control bit at position idx
    function automatic ctrl_vec_t cb(input int idx);
        return ctrl_vec_t'(1) << idx;
    endfunction

    // Place a 3-bit ALU operation code into the ALU_OP field
    function automatic ctrl_vec_t alu_op(input logic [2:0] op);
        return ctrl_vec_t'(op) << ALU_OP0;
    endfunction

    // Expose the latched vector only in EXEC/MEM/WB; register write is held
    // back until WB and memory strobes are confined to MEM.
    function automatic ctrl_vec_t gate_control(input state_e st, input ctrl_vec_t v);
        ctrl_vec_t g;
        g = v;
        case (st)
            ST_EXEC, ST_MEM, ST_WB: begin
                if (st != ST_WB) begin
                    g[REG_WRITE] = 1'b0;
                end
                if (st != ST_MEM) begin
                    g[MEM_READ]  = 1'b0;
                    g[MEM_WRITE] = 1'b0;
                end
            end
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/pipe_free_multicycle_control_instr_class_decode.sv
// Combinational decode of {opcode, func} into the 18-bit control vector and
// the instruction class that steers the multicycle FSM.
// Optional feature macro: MC_HALT_DETECT_EN (opcode 6'b111111 decodes as HALT).
module instr_class_decode
    import pipe_free_multicycle_control_pkg::*;
#(
    parameter int OP_SIZE   = 6,
    parameter int FUNC_SIZE = 6
) (
    input  logic [OP_SIZE-1:0]   i_opcode,
    input  logic [FUNC_SIZE-1:0] i_func,
    output ctrl_vec_t            o_vec,
    output instr_class_e         o_class
);

    // Common encodings shared by several table rows
    localparam ctrl_vec_t R_ALU = cb(REG_WRITE) | cb(REG_DST) | alu_op(3'b111);
    localparam ctrl_vec_t I_ALU = cb(REG_WRITE) | cb(ALU_SRC_IMM);
    localparam ctrl_vec_t MEM_ADDR = cb(ALU_SRC_IMM) | alu_op(3'b001);

    logic [5:0] op6;
    logic [5:0] fn6;

    assign op6 = 6'(i_opcode);
    assign fn6 = 6'(i_func);

    // Decode table; anything not listed is an illegal instruction
    always_comb begin
        o_vec   = '0;
        o_class = CLS_ILLEGAL;
        case (op6)
            OP_RTYPE: begin
                case (fn6)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: begin
                        o_vec   = R_ALU;
                        o_class = CLS_ALU;
                    end
                    FN_ADDU, FN_SUBU, FN_SLTU: begin
                        o_vec   = R_ALU | cb(ALU_UNSIGNED);
                        o_class = CLS_ALU;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        o_vec   = R_ALU | cb(SHIFT_SRC);
                        o_class = CLS_ALU;
                    end
                    FN_JR: begin
                        o_vec   = cb(JUMP_REG) | cb(JUMP_OR_B);
                        o_class = CLS_BRANCH;
                    end
                    FN_JALR: begin
                        // Link-writing jump needs the WB cycle
                        o_vec   = cb(REG_WRITE) | cb(REG_DST) | cb(LINK)
                                | cb(JUMP_REG) | cb(JUMP_OR_B);
                        o_class = CLS_ALU;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                o_vec   = cb(JUMP_IMM) | cb(JUMP_OR_B);
                o_class = CLS_BRANCH;
            end
            OP_JAL: begin
                o_vec   = cb(REG_WRITE) | cb(LINK) | cb(JUMP_IMM) | cb(JUMP_OR_B);
                o_class = CLS_ALU;
            end
            OP_BEQ: begin
                o_vec   = cb(BRANCH_EQ) | alu_op(3'b010) | cb(JUMP_OR_B);
                o_class = CLS_BRANCH;
            end
            OP_BNE: begin
                o_vec   = cb(BRANCH_NE) | alu_op(3'b010) | cb(JUMP_OR_B);
                o_class = CLS_BRANCH;
            end
            OP_ADDI: begin
                o_vec   = I_ALU | alu_op(3'b001);
                o_class = CLS_ALU;
            end
            OP_ADDIU: begin
                o_vec   = I_ALU | alu_op(3'b001) | cb(ALU_UNSIGNED);
                o_class = CLS_ALU;
            end
            OP_SLTI: begin
                o_vec   = I_ALU | alu_op(3'b011);
                o_class = CLS_ALU;
            end
            OP_SLTIU: begin
                o_vec   = I_ALU | alu_op(3'b011) | cb(ALU_UNSIGNED);
                o_class = CLS_ALU;
            end
            OP_ANDI: begin
                o_vec   = I_ALU | alu_op(3'b100) | cb(ZERO_EXT);
                o_class = CLS_ALU;
            end
            OP_ORI: begin
                o_vec   = I_ALU | alu_op(3'b101) | cb(ZERO_EXT);
                o_class = CLS_ALU;
            end
            OP_XORI: begin
                o_vec   = I_ALU | alu_op(3'b110) | cb(ZERO_EXT);
                o_class = CLS_ALU;
            end
            OP_LUI: begin
                // ALU op 000 passes the zero-extended immediate shifted up
                o_vec   = I_ALU | alu_op(3'b000) | cb(ZERO_EXT);
                o_class = CLS_ALU;
            end
            OP_LW: begin
                o_vec   = MEM_ADDR | cb(REG_WRITE) | cb(MEM_READ) | cb(MEM_TO_REG);
                o_class = CLS_LOAD;
            end
            OP_SW: begin
                o_vec   = MEM_ADDR | cb(MEM_WRITE);
                o_class = CLS_STORE;
            end
`ifdef MC_HALT_DETECT_EN
            OP_HALT: begin
                o_vec   = '0;
                o_class = CLS_HALT;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_free_multicycle_control.sv
// Multicycle control FSM: fetch handshake, one-cycle decode into a latched
// control vector, class-dependent EXEC/MEM/WB sequencing, retire strobes and
// a wrapping retired-instruction counter.
// Optional feature macro: MC_HALT_DETECT_EN (opcode 6'b111111 retires into HALT).
module pipe_free_multicycle_control
    import pipe_free_multicycle_control_pkg::*;
#(
    parameter int CONTROL_SIZE = 18,
    parameter int OP_SIZE      = 6,
    parameter int FUNC_SIZE    = 6,
    parameter int COUNT_W      = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [31:0]             i_instr,
    input  logic                    i_instr_valid,
    output logic                    o_instr_ready,
    input  logic                    i_mem_ready,
    output logic [CONTROL_SIZE-1:0] o_control,
    output logic [2:0]              o_state,
    output logic                    o_ir_write,
    output logic                    o_pc_write,
    output logic                    o_illegal,
    output logic                    o_busy,
    output logic [COUNT_W-1:0]      o_instr_count
);

    state_e                  state_q, state_d;
    logic [OP_SIZE-1:0]      op_q, op_d;
    logic [FUNC_SIZE-1:0]    func_q, func_d;
    ctrl_vec_t               vec_q, vec_d;
    instr_class_e            cls_q, cls_d;
    logic [CONTROL_SIZE-1:0] control_q, control_d;
    logic                    busy_q, busy_d;
    logic [COUNT_W-1:0]      count_q, count_d;

    ctrl_vec_t               dec_vec;
    instr_class_e            dec_class;
    logic                    handshake;
    logic                    retire;
    logic                    illegal;
    logic                    unused_instr_bits;

    // Only opcode and func are kept; register fields belong to the datapath
    assign unused_instr_bits = ^i_instr[31-OP_SIZE:FUNC_SIZE];

    instr_class_decode #(
        .OP_SIZE   (OP_SIZE),
        .FUNC_SIZE (FUNC_SIZE)
    ) u_decode (
        .i_opcode (op_q),
        .i_func   (func_q),
        .o_vec    (dec_vec),
        .o_class  (dec_class)
    );

    assign handshake = (state_q == ST_FETCH) & i_enable & i_instr_valid;

    // Next-state, retire and counter logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        func_d  = func_q;
        vec_d   = vec_q;
        cls_d   = cls_q;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (handshake) begin
                    op_d    = i_instr[31 -: OP_SIZE];
                    func_d  = i_instr[FUNC_SIZE-1:0];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d = dec_class;
                case (dec_class)
                    CLS_ILLEGAL: begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                        vec_d   = '0;
                        state_d = ST_FETCH;
                    end
`ifdef MC_HALT_DETECT_EN
                    CLS_HALT: begin
                        retire  = 1'b1;
                        vec_d   = '0;
                        state_d = ST_HALT;
                    end
`else
                    CLS_HALT: begin
                        // The decoder never reports HALT in this build
                        illegal = 1'b1;
                        retire  = 1'b1;
                        vec_d   = '0;
                        state_d = ST_FETCH;
                    end
`endif
                    default: begin
                        vec_d   = dec_vec;
                        state_d = ST_EXEC;
                    end
                endcase
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH: begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // Wait indefinitely for the data memory
                if (i_mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        count_d = count_q + COUNT_W'(retire & ~illegal);

        // Registered outputs are computed from the state being entered
        control_d = '0;
        control_d[CTRL_W-1:0] = gate_control(state_d, vec_d);
        busy_d = (state_d != ST_FETCH) && (state_d != ST_HALT);
    end

    // FSM and output registers, cleared asynchronously by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            func_q    <= '0;
            vec_q     <= '0;
            cls_q     <= CLS_ILLEGAL;
            control_q <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            func_q    <= func_d;
            vec_q     <= vec_d;
            cls_q     <= cls_d;
            control_q <= control_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
        end
    end

    // Same-cycle strobes are held low while reset is asserted
    assign o_instr_ready = i_rst_n & (state_q == ST_FETCH) & i_enable;
    assign o_ir_write    = i_rst_n & handshake;
    assign o_pc_write    = i_rst_n & retire;
    assign o_illegal     = i_rst_n & illegal;

    assign o_state       = state_q;
    assign o_control     = control_q;
    assign o_busy        = busy_q;
    assign o_instr_count = count_q;

endmodule

// File: tb/tb_pipe_free_multicycle_control.sv
// Self-checking bench for pipe_free_multicycle_control: directed table,
// randomized instruction stream against a class-level timeline model, and
// hand sequences for async reset mid-MEM, counter wrap and HALT.
// Honors MC_HALT_DETECT_EN when defined.
module tb_pipe_free_multicycle_control;

    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [31:0]   instr;
    logic          valid;
    logic          mr;
    logic          rdy;
    logic [17:0]   ctl;
    logic [2:0]    st;
    logic          irw;
    logic          pcw;
    logic          ill;
    logic          busy;
    logic [NW-1:0] cnt;

    always #5 clk = ~clk;

    pipe_free_multicycle_control #(
        .CONTROL_SIZE (18),
        .OP_SIZE      (6),
        .FUNC_SIZE    (6),
        .COUNT_W      (NW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_instr       (instr),
        .i_instr_valid (valid),
        .o_instr_ready (rdy),
        .i_mem_ready   (mr),
        .o_control     (ctl),
        .o_state       (st),
        .o_ir_write    (irw),
        .o_pc_write    (pcw),
        .o_illegal     (ill),
        .o_busy        (busy),
        .o_instr_count (cnt)
    );

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_ILL, K_HALT} kind_e;

    typedef struct {
        logic [31:0] ins;
        kind_e       kind;
        logic [17:0] vec;
        int unsigned mem_wait;
    } rec_t;

    typedef struct {
        logic [2:0]  st;
        logic [17:0] ctl;
        logic        pcw;
        logic        ill;
        logic        in_mem;
        logic        mem_go;
    } step_t;

    rec_t          tbl[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [NW-1:0] exp_count = '0;

    task automatic add(input logic [31:0] i, input kind_e k, input logic [17:0] v, input int unsigned w);
        rec_t r;
        r.ins = i; r.kind = k; r.vec = v; r.mem_wait = w;
        tbl.push_back(r);
    endtask

    task automatic check(input string what, input logic [2:0] e_st, input logic [17:0] e_ctl,
                         input logic e_irw, input logic e_pcw, input logic e_ill,
                         input logic e_busy, input logic e_rdy);
        logic [29:0] got;
        logic [29:0] exp;
        got = {st, ctl, irw, pcw, ill, busy, rdy, cnt};
        exp = {e_st, e_ctl, e_irw, e_pcw, e_ill, e_busy, e_rdy, exp_count};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got st=%0d ctl=%05h irw=%b pcw=%b ill=%b busy=%b rdy=%b cnt=%0d, required st=%0d ctl=%05h irw=%b pcw=%b ill=%b busy=%b rdy=%b cnt=%0d",
                     what, $time, st, ctl, irw, pcw, ill, busy, rdy, cnt,
                     e_st, e_ctl, e_irw, e_pcw, e_ill, e_busy, e_rdy, exp_count);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] scramble(input logic [31:0] ins);
        logic [31:0] r;
        r = $urandom;
        if (ins[31:26] == 6'h00) return {ins[31:26], r[25:6], ins[5:0]};
        return {ins[31:26], r[25:0]};
    endfunction

    // Apply one instruction and check every cycle from FETCH to retire
    task automatic run_instr(input logic [31:0] ins, input kind_e kind, input logic [17:0] vec,
                             input int unsigned wait_n, input int unsigned idle_n);
        step_t steps[$];
        step_t s;
        logic [17:0] exec_v;
        logic [17:0] mem_v;
        logic [17:0] wb_v;
        exec_v = vec & ~18'h00019;
        mem_v  = vec & ~18'h00001;
        wb_v   = vec & ~18'h00018;

        for (int i = 0; i < int'(idle_n); i++) begin
            en = 1'($urandom);
            valid = en ? 1'b0 : 1'($urandom);
            instr = $urandom;
            mr = 1'($urandom);
            @(negedge clk);
            check("fetch_idle", 3'd0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, en);
            tick();
        end

        en = 1'b1; valid = 1'b1; instr = ins; mr = 1'($urandom);
        @(negedge clk);
        check("fetch_handshake", 3'd0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        s = '{st: 3'd1, ctl: 18'h0, pcw: (kind == K_ILL) || (kind == K_HALT),
              ill: (kind == K_ILL), in_mem: 1'b0, mem_go: 1'b0};
        steps.push_back(s);
        s.pcw = 1'b0; s.ill = 1'b0;
        case (kind)
            K_ALU: begin
                s.st = 3'd2; s.ctl = exec_v; steps.push_back(s);
                s.st = 3'd4; s.ctl = wb_v; s.pcw = 1'b1; steps.push_back(s);
            end
            K_LOAD, K_STORE: begin
                s.st = 3'd2; s.ctl = exec_v; steps.push_back(s);
                s.st = 3'd3; s.ctl = mem_v; s.in_mem = 1'b1;
                for (int w = 0; w < int'(wait_n); w++) steps.push_back(s);
                s.mem_go = 1'b1; s.pcw = (kind == K_STORE); steps.push_back(s);
                if (kind == K_LOAD) begin
                    s.st = 3'd4; s.ctl = wb_v; s.pcw = 1'b1; s.in_mem = 1'b0; s.mem_go = 1'b0;
                    steps.push_back(s);
                end
            end
            K_BRANCH: begin
                s.st = 3'd2; s.ctl = exec_v; s.pcw = 1'b1; steps.push_back(s);
            end
            K_HALT: begin
                s.st = 3'd5; s.ctl = 18'h0;
                for (int h = 0; h < 6; h++) steps.push_back(s);
            end
            default: ;
        endcase

        foreach (steps[k]) begin
            en = 1'($urandom); valid = 1'($urandom); instr = $urandom;
            mr = steps[k].in_mem ? steps[k].mem_go : 1'($urandom);
            @(negedge clk);
            check("in_flight", steps[k].st, steps[k].ctl, 1'b0, steps[k].pcw, steps[k].ill,
                  (steps[k].st inside {3'd1, 3'd2, 3'd3, 3'd4}), 1'b0);
            if (steps[k].pcw && !steps[k].ill) exp_count = exp_count + 1'b1;
            tick();
        end
        $display("instr %08h kind %0d wait %0d count %0d", ins, kind, wait_n, exp_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        rst_n = 1'b0; en = 1'b1; valid = 1'b1; instr = 32'h00221821; mr = 1'b1;

        add(32'h00221821, K_ALU,    18'h01C85, 0); // ADDU
        add(32'h00221820, K_ALU,    18'h01C05, 0); // ADD
        add(32'h00021080, K_ALU,    18'h01C07, 0); // SLL
        add(32'h0022182B, K_ALU,    18'h01C85, 0); // SLTU
        add(32'h03E00008, K_BRANCH, 18'h28000, 0); // JR
        add(32'h0040F809, K_ALU,    18'h2C005, 0); // JALR
        add(32'h08000010, K_BRANCH, 18'h30000, 0); // J
        add(32'h0C000010, K_ALU,    18'h34001, 0); // JAL
        add(32'h10220003, K_BRANCH, 18'h20820, 0); // BEQ
        add(32'h14220003, K_BRANCH, 18'h20840, 0); // BNE
        add(32'h24220005, K_ALU,    18'h00681, 0); // ADDIU
        add(32'h3422FFFF, K_ALU,    18'h01701, 0); // ORI
        add(32'h3C021234, K_ALU,    18'h00301, 0); // LUI
        add(32'h8C220004, K_LOAD,   18'h02609, 3); // LW, three stalled MEM cycles
        add(32'hAC220004, K_STORE,  18'h00610, 0); // SW, memory ready at once
        add(32'hF8000000, K_ILL,    18'h00000, 0); // unknown opcode
        add(32'h0000003F, K_ILL,    18'h00000, 0); // unknown R-type func
`ifndef MC_HALT_DETECT_EN
        add(32'hFC000000, K_ILL,    18'h00000, 0); // halt opcode without detection
`endif

        // Reset holds everything low, even with a pending handshake
        #2;
        check("reset_async", 3'd0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_clocked", 3'd0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Directed table; first entry handshakes on the first edge after reset
        foreach (tbl[i]) run_instr(tbl[i].ins, tbl[i].kind, tbl[i].vec, tbl[i].mem_wait, 0);

        // Randomized stream
        repeat (150) begin
            k = $urandom_range(0, tbl.size() - 1);
            run_instr(scramble(tbl[k].ins), tbl[k].kind, tbl[k].vec,
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset asserted between edges while a load waits in MEM
        en = 1'b1; valid = 1'b1; instr = 32'h8C220004; mr = 1'b0;
        @(negedge clk);
        check("lw_fetch", 3'd0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        check("lw_decode", 3'd1, 18'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        check("lw_exec", 3'd2, 18'h02600, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        check("lw_mem", 3'd3, 18'h02608, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = '0;
        check("reset_mid_mem", 3'd0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Sixteen retires from zero wrap the 4-bit counter back to zero
        repeat (16) run_instr(32'h00221821, K_ALU, 18'h01C85, 0, 0);
        en = 1'b0; valid = 1'b0; mr = 1'b1;
        @(negedge clk);
        check("count_wrap", 3'd0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

`ifdef MC_HALT_DETECT_EN
        // Halt retires in DECODE and parks until reset
        run_instr(32'hFC000000, K_HALT, 18'h0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = '0;
        check("halt_reset", 3'd0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        run_instr(32'h00221821, K_ALU, 18'h01C85, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
